// File: rtl/spi_slave_pkg.sv
// Shared types and sizing helpers for the SPI slave.
// Imported by the SPI slave top and its synchronizer sub-module.
package spi_slave_pkg;

    localparam int WIDTH_DEF    = 8;
    localparam int SYNC_STG_DEF = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Bit counter must hold 0..width
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/spi_slave_if.sv
// SPI pins plus local Tx/Rx data path of the SPI slave, grouped as one bundle.
interface spi_slave_if #(parameter int WIDTH = 8);

    logic             cpol;
    logic             cpha;
    logic             sclk;
    logic             ss_n;
    logic             mosi;
    logic             miso;
    logic             miso_en;
    logic [WIDTH-1:0] tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;
    logic             tx_underrun;
    logic             busy;

    modport slave (
        input  cpol, cpha, sclk, ss_n, mosi, tx_data, tx_valid,
        output miso, miso_en, tx_ready, rx_data, rx_valid, tx_underrun, busy
    );

    modport master (
        output cpol, cpha, sclk, ss_n, mosi, tx_data, tx_valid,
        input  miso, miso_en, tx_ready, rx_data, rx_valid, tx_underrun, busy
    );

endinterface

// File: rtl/spi_slave_sync_edge.sv
// N-stage synchronizer for an asynchronous pin with rise/fall pulses on the synced value.
module spi_sync_edge
    import spi_slave_pkg::*;
#(
    parameter int   SYNC_STG = SYNC_STG_DEF,
    parameter logic RST_VAL  = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STG-1:0] r_sync;
    logic                r_prev;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= {SYNC_STG{RST_VAL}};
            r_prev <= RST_VAL;
        end else begin
            r_sync <= {r_sync[SYNC_STG-2:0], i_async};
            r_prev <= r_sync[SYNC_STG-1];
        end
    end

    assign o_sync = r_sync[SYNC_STG-1];
    assign o_rise =  r_sync[SYNC_STG-1] & ~r_prev;
    assign o_fall = ~r_sync[SYNC_STG-1] &  r_prev;

endmodule

// File: rtl/spi_slave.sv
// SPI slave: oversampled SCLK/SS_n/MOSI, MSB-first shifting in all four CPOL/CPHA modes,
// single-entry Tx holding buffer feeding MISO, Rx word pulse on completion.
//
//   state    | meaning
//   ST_IDLE  | SS_n high; SCLK ignored, counter at 0, CPOL/CPHA tracked
//   ST_SHIFT | selected; shifting words back-to-back until SS_n rises
module spi_slave
    import spi_slave_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int SYNC_STG = SYNC_STG_DEF
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    spi_slave_if.slave      io_spi
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_cpol;
    logic               r_cpha;
    logic [SYNC_STG-1:0] r_mosi_sync;
    logic [CNT_W-1:0]   r_bit_cnt;
    logic [WIDTH-1:0]   r_rx_shift;
    logic [WIDTH-1:0]   r_rx_data;
    logic               r_rx_valid;
    logic [WIDTH-1:0]   r_tx_shift;
    logic [WIDTH-1:0]   r_tx_buf;
    logic               r_tx_full;
    logic               r_tx_underrun;
    logic               r_miso;
    logic               r_start_pend;

    logic w_sclk_sync, w_sclk_rise, w_sclk_fall;
    logic w_ss_sync, w_ss_rise, w_ss_fall;
    logic w_mosi, w_in_shift, w_sclk_edge, w_lead, w_trail;
    logic w_sample, w_shift, w_last, w_frame_start, w_pend_start, w_start, w_end, w_accept;
    logic [WIDTH-1:0] w_word;

    spi_sync_edge #(.SYNC_STG(SYNC_STG), .RST_VAL(1'b0)) u_sync_sclk (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_async (io_spi.sclk),
        .o_sync  (w_sclk_sync),
        .o_rise  (w_sclk_rise),
        .o_fall  (w_sclk_fall)
    );

    spi_sync_edge #(.SYNC_STG(SYNC_STG), .RST_VAL(1'b1)) u_sync_ss (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_async (io_spi.ss_n),
        .o_sync  (w_ss_sync),
        .o_rise  (w_ss_rise),
        .o_fall  (w_ss_fall)
    );

    // MOSI gets the same depth as SCLK so the sample lines up with its edge event
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mosi_sync <= '0;
            r_cpol      <= 1'b0;
            r_cpha      <= 1'b0;
        end else begin
            r_mosi_sync <= {r_mosi_sync[SYNC_STG-2:0], io_spi.mosi};
            if (w_ss_sync) begin
                r_cpol <= io_spi.cpol;
                r_cpha <= io_spi.cpha;
            end
        end
    end

    assign w_mosi        = r_mosi_sync[SYNC_STG-1];
    assign w_in_shift    = (r_state == ST_SHIFT);
    assign w_sclk_edge   = w_sclk_rise | w_sclk_fall;
    assign w_lead        = w_sclk_edge & (w_sclk_sync != r_cpol);
    assign w_trail       = w_sclk_edge & (w_sclk_sync == r_cpol);
    assign w_sample      = w_in_shift & (r_cpha ? w_trail : w_lead);
    assign w_shift       = w_in_shift & (r_cpha ? w_lead : w_trail);
    assign w_last        = w_sample & (r_bit_cnt == CNT_W'(WIDTH - 1));
    assign w_end         = w_in_shift & w_ss_rise;
    assign w_frame_start = (r_state == ST_IDLE) & w_ss_fall;
    // Follow-on word is pulled from the buffer at the first shift edge after completion
    assign w_pend_start  = w_shift & r_start_pend & ~w_end;
    assign w_start       = w_frame_start | w_pend_start;
    assign w_accept      = io_spi.tx_valid & ~r_tx_full;
    assign w_word        = r_tx_full ? r_tx_buf : '0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_ss_fall) w_state_nxt = ST_SHIFT;
            ST_SHIFT: if (w_ss_rise) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tx_buf      <= '0;
            r_tx_full     <= 1'b0;
            r_tx_underrun <= 1'b0;
        end else begin
            r_tx_underrun <= w_start & ~r_tx_full;
            if (w_start)  r_tx_full <= 1'b0;
            if (w_accept) begin
                r_tx_full <= 1'b1;
                r_tx_buf  <= io_spi.tx_data;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_bit_cnt    <= '0;
            r_rx_shift   <= '0;
            r_rx_data    <= '0;
            r_rx_valid   <= 1'b0;
            r_tx_shift   <= '0;
            r_miso       <= 1'b0;
            r_start_pend <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            if (w_end) begin
                r_bit_cnt    <= '0;
                r_rx_shift   <= '0;
                r_tx_shift   <= '0;
                r_miso       <= 1'b0;
                r_start_pend <= 1'b0;
            end else begin
                if (w_sample) begin
                    r_rx_shift <= {r_rx_shift[WIDTH-2:0], w_mosi};
                    if (w_last) begin
                        r_bit_cnt    <= '0;
                        r_rx_data    <= {r_rx_shift[WIDTH-2:0], w_mosi};
                        r_rx_valid   <= 1'b1;
                        r_start_pend <= 1'b1;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                    end
                end
                // CPHA=1 waits for the leading edge to present the MSB
                if (w_frame_start) begin
                    if (r_cpha) begin
                        r_tx_shift <= w_word;
                    end else begin
                        r_miso     <= w_word[WIDTH-1];
                        r_tx_shift <= w_word << 1;
                    end
                end else if (w_pend_start) begin
                    r_miso       <= w_word[WIDTH-1];
                    r_tx_shift   <= w_word << 1;
                    r_start_pend <= 1'b0;
                end else if (w_shift) begin
                    r_miso     <= r_tx_shift[WIDTH-1];
                    r_tx_shift <= r_tx_shift << 1;
                end
            end
        end
    end

    assign io_spi.miso        = r_miso;
    assign io_spi.miso_en     = ~w_ss_sync;
    assign io_spi.tx_ready    = ~r_tx_full;
    assign io_spi.rx_data     = r_rx_data;
    assign io_spi.rx_valid    = r_rx_valid;
    assign io_spi.tx_underrun = r_tx_underrun;
    assign io_spi.busy        = w_in_shift;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a bit-level SPI master plus a word-level model of Tx/Rx traffic.
module tb_spi_slave;
    import spi_slave_pkg::*;

    localparam int H = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_slave_if #(.WIDTH(8)) bus ();

    spi_slave #(.WIDTH(8), .SYNC_STG(2)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_spi  (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] tx_model_q[$];
    logic [7:0] rx_exp_q[$];
    int  underrun_exp  = 0;
    int  underrun_seen = 0;
    int  rxv_seen      = 0;
    bit  chk_ready     = 1'b0;
    logic prev_rxv     = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Word-level checks on every cycle out of reset
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.rx_valid) begin
                rxv_seen++;
                check("rx_valid_width", 32'(prev_rxv), 32'd0);
                if (rx_exp_q.size() == 0) check("rx_valid_unexpected", 32'd1, 32'd0);
                else check("rx_data", 32'(bus.rx_data), 32'(rx_exp_q.pop_front()));
            end
            if (bus.tx_underrun) underrun_seen++;
            if (chk_ready) check("tx_ready_hold", 32'(bus.tx_ready), 32'd1);
            prev_rxv = bus.rx_valid;
        end else begin
            prev_rxv = 1'b0;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_miso"},        32'(bus.miso),        32'd0);
        check({tag, "_miso_en"},     32'(bus.miso_en),     32'd0);
        check({tag, "_tx_ready"},    32'(bus.tx_ready),    32'd1);
        check({tag, "_rx_data"},     32'(bus.rx_data),     32'd0);
        check({tag, "_rx_valid"},    32'(bus.rx_valid),    32'd0);
        check({tag, "_tx_underrun"}, 32'(bus.tx_underrun), 32'd0);
        check({tag, "_busy"},        32'(bus.busy),        32'd0);
    endtask

    task automatic load_tx(input logic [7:0] d);
        int n = 0;
        @(negedge clk);
        while (!bus.tx_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!bus.tx_ready) begin
            check("tx_ready_timeout", 32'd0, 32'd1);
        end else begin
            bus.tx_data  = d;
            bus.tx_valid = 1'b1;
            @(posedge clk);
            tx_model_q.push_back(d);
            @(negedge clk);
            bus.tx_valid = 1'b0;
        end
    endtask

    // A word starts at SS_n fall and, after each completed word, at the next shift edge
    function automatic logic [7:0] model_start_word();
        if (tx_model_q.size() > 0) return tx_model_q.pop_front();
        underrun_exp++;
        return 8'h00;
    endfunction

    task automatic spi_frame(input int mode, input logic [7:0] w0, input logic [7:0] w1,
                             input int nbits, input bit do_rst,
                             output logic [7:0] m0, output logic [7:0] m1);
        logic [15:0] stream;
        logic [7:0]  exp_m [2];
        logic [7:0]  got   [2];
        logic        cpol_v, cpha_v, b;
        int          k, rxv0, nw_full, nb;
        stream  = {w0, w1};
        cpol_v  = mode[1];
        cpha_v  = mode[0];
        rxv0    = rxv_seen;
        nw_full = nbits / 8;
        got[0] = 8'h00; got[1] = 8'h00; exp_m[0] = 8'h00; exp_m[1] = 8'h00;
        @(negedge clk);
        bus.cpol = cpol_v; bus.cpha = cpha_v; bus.sclk = cpol_v; bus.ss_n = 1'b1;
        repeat (6) @(negedge clk);
        bus.ss_n = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            k = i / 8;
            if (i % 8 == 0) exp_m[k] = model_start_word();
            b = stream[15 - i];
            if (!cpha_v) begin
                bus.mosi = b;
                repeat (H) @(negedge clk);
                bus.sclk = ~cpol_v;
                got[k] = {got[k][6:0], bus.miso};
                if (i % 8 == 7) rx_exp_q.push_back(k == 0 ? w0 : w1);
                repeat (H) @(negedge clk);
                bus.sclk = cpol_v;
            end else begin
                repeat (H) @(negedge clk);
                bus.sclk = ~cpol_v;
                bus.mosi = b;
                repeat (H) @(negedge clk);
                bus.sclk = cpol_v;
                got[k] = {got[k][6:0], bus.miso};
                if (i % 8 == 7) rx_exp_q.push_back(k == 0 ? w0 : w1);
            end
        end
        if (do_rst) begin
            repeat (2) @(negedge clk);
            #1 rst_n = 1'b0;
            #1 check_reset_outputs("mid_frame_rst");
            tx_model_q.delete();
            rx_exp_q.delete();
            bus.ss_n = 1'b1; bus.sclk = cpol_v; bus.mosi = 1'b0;
            repeat (3) @(negedge clk);
            rst_n = 1'b1;
            repeat (2 * H) @(negedge clk);
            check("post_rst_busy", 32'(bus.busy), 32'd0);
        end else begin
            if (!cpha_v && nbits % 8 == 0) void'(model_start_word());
            repeat (H) @(negedge clk);
            bus.ss_n = 1'b1;
            repeat (2 * H) @(negedge clk);
            for (int j = 0; j < nw_full; j++) check("miso_word", 32'(got[j]), 32'(exp_m[j]));
            nb = nbits % 8;
            if (nb != 0) check("miso_partial", 32'(got[nw_full]), 32'(exp_m[nw_full] >> (8 - nb)));
            check("rx_valid_count", 32'(rxv_seen - rxv0), 32'(nw_full));
            check("underrun_count", 32'(underrun_seen), 32'(underrun_exp));
            check("rx_pending", 32'(rx_exp_q.size()), 32'd0);
            check("end_busy", 32'(bus.busy), 32'd0);
            check("end_miso_en", 32'(bus.miso_en), 32'd0);
        end
        m0 = got[0];
        m1 = got[1];
    endtask

    initial begin
        repeat (50000) @(posedge clk);
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [7:0] m0, m1;
        int u0;
        bus.cpol = 1'b0; bus.cpha = 1'b0; bus.sclk = 1'b0; bus.ss_n = 1'b1;
        bus.mosi = 1'b0; bus.tx_data = 8'h00; bus.tx_valid = 1'b0;
        repeat (4) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Mode 0 basic transfer
        load_tx(8'hA5);
        check("tx_ready_after_load", 32'(bus.tx_ready), 32'd0);
        spi_frame(0, 8'h3C, 8'h00, 8, 1'b0, m0, m1);
        check("mode0_miso_lit", 32'(m0), 32'h0000_00A5);
        check("mode0_rx_lit", 32'(bus.rx_data), 32'h0000_003C);

        // All four modes with C3 both ways
        for (int md = 0; md < 4; md++) begin
            load_tx(8'hC3);
            spi_frame(md, 8'hC3, 8'h00, 8, 1'b0, m0, m1);
            check("modes_miso_lit", 32'(m0), 32'h0000_00C3);
            check("modes_rx_lit", 32'(bus.rx_data), 32'h0000_00C3);
        end

        // Two words under one select, second Tx word loaded while the first shifts
        load_tx(8'h55);
        fork
            spi_frame(0, 8'h01, 8'h80, 16, 1'b0, m0, m1);
            load_tx(8'hAA);
        join
        check("two_word_miso0_lit", 32'(m0), 32'h0000_0055);
        check("two_word_miso1_lit", 32'(m1), 32'h0000_00AA);
        check("two_word_rx_lit", 32'(bus.rx_data), 32'h0000_0080);

        // Abort after 5 bits, then a clean frame
        spi_frame(0, 8'hB7, 8'h00, 5, 1'b0, m0, m1);
        check("abort_rx_held_lit", 32'(bus.rx_data), 32'h0000_0080);
        spi_frame(0, 8'hF0, 8'h00, 8, 1'b0, m0, m1);
        check("after_abort_rx_lit", 32'(bus.rx_data), 32'h0000_00F0);

        // Empty Tx buffer in mode 1: MISO zero, one underrun, ready never drops
        u0 = underrun_seen;
        chk_ready = 1'b1;
        spi_frame(1, 8'h6B, 8'h00, 8, 1'b0, m0, m1);
        chk_ready = 1'b0;
        check("underrun_miso_lit", 32'(m0), 32'h0000_0000);
        check("underrun_pulses_lit", 32'(underrun_seen - u0), 32'd1);
        check("underrun_rx_lit", 32'(bus.rx_data), 32'h0000_006B);

        // Reset after 3 bits, then a full frame
        spi_frame(0, 8'h5C, 8'h00, 3, 1'b1, m0, m1);
        spi_frame(0, 8'h99, 8'h00, 8, 1'b0, m0, m1);
        check("post_rst_rx_lit", 32'(bus.rx_data), 32'h0000_0099);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
